// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the run/step clock-enable sequencer.
package cpu_ctrl_pkg;

    // Sequencer state, also exported on the mode output. Encoding 3 is unused
    // and treated as IDLE by the state machine.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HALT = 2'd2
    } run_mode_t;

endpackage

// File: rtl/cpu_clock_ctrl_if.sv
// Operator inputs, halt request and clock-enable status between the device
// I/O mapping (master) and the run/step sequencer (slave).
interface cpu_clock_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_ctrl_pkg::*;

    logic             clk_auto_en;
    logic             clk_step;
    logic             halt;
    logic             cpu_ce;
    run_mode_t        mode;
    logic [CNT_W-1:0] tick_count;

    modport master (
        output clk_auto_en,
        output clk_step,
        output halt,
        input  cpu_ce,
        input  mode,
        input  tick_count
    );

    modport slave (
        input  clk_auto_en,
        input  clk_step,
        input  halt,
        output cpu_ce,
        output mode,
        output tick_count
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizer chain plus debounce counter for one asynchronous operator input.
// The stable level only follows the synced input after it has differed from
// the stable level for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt_q;
    logic                   stable_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain: raw enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing cycles; accept the new level at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (synced == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q    <= '0;
            stable_q <= synced;
        end else begin
            cnt_q <= cnt_q + DB_W'(1);
        end
    end

    assign level = stable_q;
endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/step sequencer: turns the debounced run switch and step button into
// single-cycle CPU clock-enable pulses, tracks the run mode and counts pulses.
module cpu_clock_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int AUTO_DIV        = 25_000_000,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_clock_ctrl_if.slave      bus
);
    localparam int DIV_W = $clog2(AUTO_DIV);

    logic             auto_on;
    logic             step_level;
    logic             step_level_q;
    logic             step_rise;

    run_mode_t        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic [CNT_W-1:0] tick_q;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_auto_db (
        .clk  (clk),
        .reset(reset),
        .raw  (bus.clk_auto_en),
        .level(auto_on)
    );

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk  (clk),
        .reset(reset),
        .raw  (bus.clk_step),
        .level(step_level)
    );

    // Delayed debounced step level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_level_q <= 1'b0;
        end else begin
            step_level_q <= step_level;
        end
    end

    assign step_rise = step_level & ~step_level_q;

    // State, divider, clock-enable and pulse counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MODE_IDLE;
            div_q   <= '0;
            ce_q    <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ce_q    <= ce_d;
            if (ce_d) begin
                tick_q <= tick_q + CNT_W'(1);
            end
        end
    end

    // Next-state, divider and pulse decision; halt overrides any pulse.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        case (state_q)
            MODE_RUN: begin
                if (bus.halt) begin
                    state_d = MODE_HALT;
                end else if (!auto_on) begin
                    state_d = MODE_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_W'(AUTO_DIV - 1)) begin
                    ce_d  = 1'b1;
                    div_d = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            MODE_HALT: begin
                state_d = MODE_HALT;
            end
            default: begin
                if (bus.halt) begin
                    state_d = MODE_HALT;
                end else begin
                    ce_d = step_rise;
                    if (auto_on) begin
                        state_d = MODE_RUN;
                        div_d   = '0;
                    end else begin
                        state_d = MODE_IDLE;
                    end
                end
            end
        endcase
    end

    assign bus.cpu_ce     = ce_q;
    assign bus.mode       = state_q;
    assign bus.tick_count = tick_q;
endmodule
